// File: rtl/stage2_conv_sched_pkg.sv
// stage2_conv_sched_pkg: parameter defaults, FSM state encoding and small
// width helpers shared by the stage-2 conv scheduler and its tag FIFO.
package stage2_conv_sched_pkg;

   localparam int ST2_CO       = 3;
   localparam int ST2_OY       = 8;
   localparam int ST2_OX       = 8;
   localparam int ST2_PIPE_LAT = 3;
   localparam int ST2_CREDITS  = 4;

   typedef enum logic [1:0] {
      ST2_S_IDLE  = 2'd0,
      ST2_S_ISSUE = 2'd1,
      ST2_S_DRAIN = 2'd2,
      ST2_S_DONE  = 2'd3
   } st2_state_e;

   // Index width for a range of n values; never narrower than one bit.
   function automatic int st2_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int st2_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/stage2_conv_sched_tag_fifo.sv
// stage2_tag_fifo: small synchronous FIFO holding {co,y,x} tags of beats in
// flight. Head is combinational so a result can be tagged in the cycle it
// returns. Push and pop in the same cycle are accepted even when full; a pop
// of an empty FIFO is ignored (the push, if any, is still stored).
module stage2_tag_fifo
   import stage2_conv_sched_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = st2_w(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign o_full  = (count_q == CNT_FULL);
   assign o_empty = (count_q == '0);
   assign pop_ok  = i_pop && !o_empty;
   assign push_ok = i_push && (!o_full || pop_ok);
   assign o_head  = mem_q[rd_ptr_q];

   // Next pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Tag storage; contents are don't-care until written, head is gated by the user
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= i_push_data;
      end
   end

endmodule

// File: rtl/stage2_conv_sched.sv
// stage2_conv_sched: walks every (co, oy, ox) output point of the stage-2 conv
// layer, issuing one engine beat per point under credit and fmap-ready
// throttling, and tags each returning engine result with its coordinates.
// Optional ST2_SCHED_PERF_EN adds stall and pass-length counters.
module stage2_conv_sched
   import stage2_conv_sched_pkg::*;
#(
   parameter int CO       = ST2_CO,
   parameter int OY       = ST2_OY,
   parameter int OX       = ST2_OX,
   parameter int PIPE_LAT = ST2_PIPE_LAT,
   parameter int CREDITS  = ST2_CREDITS
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_start,
   input  logic                 i_fmap_ready,
   output logic                 o_in_valid,
   output logic [st2_w(CO)-1:0] o_co_idx,
   output logic [st2_w(OY)-1:0] o_win_y,
   output logic [st2_w(OX)-1:0] o_win_x,
   input  logic                 i_ot_valid,
   output logic                 o_res_valid,
   output logic [st2_w(CO)-1:0] o_res_co,
   output logic [st2_w(OY)-1:0] o_res_y,
   output logic [st2_w(OX)-1:0] o_res_x,
   input  logic                 i_credit_ret,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err
`ifdef ST2_SCHED_PERF_EN
   ,
   output logic [15:0]          o_stall_cnt,
   output logic [19:0]          o_pass_cyc
`endif
);

   localparam int CO_W   = st2_w(CO);
   localparam int OY_W   = st2_w(OY);
   localparam int OX_W   = st2_w(OX);
   localparam int TAG_W  = CO_W + OY_W + OX_W;
   localparam int FIFO_D = st2_max(PIPE_LAT + 1, CREDITS);
   localparam int CR_W   = $clog2(CREDITS + 1);
   localparam int IF_W   = $clog2(CO * OY * OX + 1);

   localparam logic [CO_W-1:0] CO_LAST = CO_W'(CO - 1);
   localparam logic [OY_W-1:0] OY_LAST = OY_W'(OY - 1);
   localparam logic [OX_W-1:0] OX_LAST = OX_W'(OX - 1);
   localparam logic [CR_W-1:0] CR_MAX  = CR_W'(CREDITS);

   st2_state_e       state_q, state_d;
   logic [CO_W-1:0]  co_q, co_d;
   logic [OY_W-1:0]  oy_q, oy_d;
   logic [OX_W-1:0]  ox_q, ox_d;
   logic [CR_W-1:0]  credit_q, credit_d;
   logic [IF_W-1:0]  inflight_q, inflight_d;
   logic             err_q, err_d;
   logic             fire;
   logic             last_pt;
   logic             credit_ovf;
   logic             fifo_full, fifo_empty;
   logic             fifo_ovf, fifo_udf;
   logic             res_hit;
   logic [TAG_W-1:0] head_tag;

   assign fire    = (state_q == ST2_S_ISSUE) && i_fmap_ready && (credit_q != '0);
   assign last_pt = (co_q == CO_LAST) && (oy_q == OY_LAST) && (ox_q == OX_LAST);

   // A pop always frees a slot when the FIFO is non-empty, so a full FIFO only
   // overflows when no result returns in the same cycle.
   assign fifo_ovf = fire && fifo_full && !i_ot_valid;
   assign fifo_udf = i_ot_valid && fifo_empty;
   assign res_hit  = i_ot_valid && !fifo_empty;

   assign o_in_valid  = fire;
   assign o_co_idx    = co_q;
   assign o_win_y     = oy_q;
   assign o_win_x     = ox_q;
   assign o_res_valid = i_ot_valid;
   assign {o_res_co, o_res_y, o_res_x} = res_hit ? head_tag : '0;
   assign o_busy = (state_q == ST2_S_ISSUE) || (state_q == ST2_S_DRAIN);
   assign o_done = (state_q == ST2_S_DONE);
   assign o_err  = err_q;

   stage2_tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (FIFO_D)
   ) u_tag_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (fire),
      .i_push_data ({co_q, oy_q, ox_q}),
      .i_pop       (i_ot_valid),
      .o_head      (head_tag),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty)
   );

   // Pass sequencing; DRAIN exits on the cycle the last result is consumed so
   // o_done follows the final result by exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST2_S_IDLE:  if (i_start) state_d = ST2_S_ISSUE;
         ST2_S_ISSUE: if (fire && last_pt) state_d = ST2_S_DRAIN;
         ST2_S_DRAIN: if (inflight_d == '0) state_d = ST2_S_DONE;
         ST2_S_DONE:  state_d = ST2_S_IDLE;
         default:     state_d = ST2_S_IDLE;
      endcase
   end

   // Output-point walk: ox innermost, co outermost; the final point wraps all to 0
   always_comb begin
      co_d = co_q;
      oy_d = oy_q;
      ox_d = ox_q;
      if (fire) begin
         if (ox_q == OX_LAST) begin
            ox_d = '0;
            if (oy_q == OY_LAST) begin
               oy_d = '0;
               co_d = (co_q == CO_LAST) ? '0 : co_q + 1'b1;
            end else begin
               oy_d = oy_q + 1'b1;
            end
         end else begin
            ox_d = ox_q + 1'b1;
         end
      end
   end

   // Credit, in-flight and sticky error bookkeeping
   always_comb begin
      credit_d   = credit_q;
      inflight_d = inflight_q;
      credit_ovf = 1'b0;
      if (fire && !i_credit_ret) begin
         credit_d = credit_q - 1'b1;
      end else if (!fire && i_credit_ret) begin
         if (credit_q == CR_MAX) begin
            credit_ovf = 1'b1;
         end else begin
            credit_d = credit_q + 1'b1;
         end
      end
      if (fire && !i_ot_valid) begin
         inflight_d = inflight_q + 1'b1;
      end else if (!fire && i_ot_valid && (inflight_q != '0)) begin
         inflight_d = inflight_q - 1'b1;
      end
      err_d = err_q | credit_ovf | fifo_ovf | fifo_udf;
   end

   // State and counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST2_S_IDLE;
         co_q       <= '0;
         oy_q       <= '0;
         ox_q       <= '0;
         credit_q   <= CR_MAX;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         co_q       <= co_d;
         oy_q       <= oy_d;
         ox_q       <= ox_d;
         credit_q   <= credit_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

`ifdef ST2_SCHED_PERF_EN
   logic [15:0] stall_q;
   logic [19:0] pass_q;
   logic        start_acc;

   assign start_acc   = (state_q == ST2_S_IDLE) && i_start;
   assign o_stall_cnt = stall_q;
   assign o_pass_cyc  = pass_q;

   // Count ISSUE cycles that could not fire (fmap or credit stall)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
      end else if (start_acc) begin
         stall_q <= '0;
      end else if ((state_q == ST2_S_ISSUE) && !fire && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   // Pass length: every non-idle cycle from the one after i_start through DONE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pass_q <= '0;
      end else if (start_acc) begin
         pass_q <= '0;
      end else if ((state_q != ST2_S_IDLE) && (pass_q != 20'hFFFFF)) begin
         pass_q <= pass_q + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_stage2_conv_sched.sv
// tb_stage2_conv_sched: directed/randomised bench for the stage-2 scheduler.
// The expected issue order is built from nested loops over the layer shape;
// a fixed-latency engine model and a downstream credit model drive the DUT.
module tb_stage2_conv_sched;

   localparam int CO       = 2;
   localparam int OY       = 2;
   localparam int OX       = 3;
   localparam int PIPE_LAT = 3;
   localparam int CREDITS  = 4;
   localparam int TOTAL    = CO * OY * OX;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       i_start;
   logic       i_fmap_ready;
   logic       o_in_valid;
   logic [0:0] o_co_idx;
   logic [0:0] o_win_y;
   logic [1:0] o_win_x;
   logic       i_ot_valid;
   logic       o_res_valid;
   logic [0:0] o_res_co;
   logic [0:0] o_res_y;
   logic [1:0] o_res_x;
   logic       i_credit_ret;
   logic       o_busy;
   logic       o_done;
   logic       o_err;
`ifdef ST2_SCHED_PERF_EN
   logic [15:0] o_stall_cnt;
   logic [19:0] o_pass_cyc;
`endif

   logic [PIPE_LAT-1:0] eng_q;
   logic spur       = 1'b0;
   logic auto_ret   = 1'b0;
   logic manual_ret = 1'b0;
   logic skip_res   = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_issue_q[$];
   int inflight_q[$];
   int issue_cnt, res_cnt, credit_m, stall_m;
   int first_issue_cyc, last_issue_cyc, last_res_cyc, start_cyc, done_cyc;
   int mon_t;

   stage2_conv_sched #(
      .CO       (CO),
      .OY       (OY),
      .OX       (OX),
      .PIPE_LAT (PIPE_LAT),
      .CREDITS  (CREDITS)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_start      (i_start),
      .i_fmap_ready (i_fmap_ready),
      .o_in_valid   (o_in_valid),
      .o_co_idx     (o_co_idx),
      .o_win_y      (o_win_y),
      .o_win_x      (o_win_x),
      .i_ot_valid   (i_ot_valid),
      .o_res_valid  (o_res_valid),
      .o_res_co     (o_res_co),
      .o_res_y      (o_res_y),
      .o_res_x      (o_res_x),
      .i_credit_ret (i_credit_ret),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err)
`ifdef ST2_SCHED_PERF_EN
      ,
      .o_stall_cnt  (o_stall_cnt),
      .o_pass_cyc   (o_pass_cyc)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Engine: fixed pipeline, each beat returns PIPE_LAT cycles after issue
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) eng_q <= '0;
      else          eng_q <= {eng_q[PIPE_LAT-2:0], o_in_valid};
   end

   assign i_ot_valid   = eng_q[PIPE_LAT-1] | spur;
   assign i_credit_ret = manual_ret | (auto_ret & i_ot_valid);

   function automatic int tag_of(input int co, input int y, input int x);
      return co * 64 + y * 8 + x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Observe issues and results; keep the downstream credit model current
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (o_in_valid) begin
            chk("issue_fmap_ready", i_fmap_ready, 1);
            chk("issue_has_credit", credit_m > 0, 1);
            chk("issue_expected", exp_issue_q.size() != 0, 1);
            if (exp_issue_q.size() != 0) begin
               mon_t = exp_issue_q.pop_front();
               chk("issue_tag", tag_of(o_co_idx, o_win_y, o_win_x), mon_t);
               inflight_q.push_back(mon_t);
            end
            if (issue_cnt == 0) first_issue_cyc = cyc;
            last_issue_cyc = cyc;
            issue_cnt++;
         end
         if (o_res_valid && !skip_res) begin
            chk("res_expected", inflight_q.size() != 0, 1);
            if (inflight_q.size() != 0) begin
               mon_t = inflight_q.pop_front();
               chk("res_tag", tag_of(o_res_co, o_res_y, o_res_x), mon_t);
            end
            res_cnt++;
            last_res_cyc = cyc;
         end
         if (o_busy && (issue_cnt < TOTAL) && !o_in_valid) stall_m++;
         if (o_in_valid && !i_credit_ret) credit_m--;
         else if (!o_in_valid && i_credit_ret && credit_m < CREDITS) credit_m++;
      end
   end

   task automatic do_reset();
      reset_n    = 1'b0;
      i_start    = 1'b0;
      i_fmap_ready = 1'b1;
      manual_ret = 1'b0;
      spur       = 1'b0;
      skip_res   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_valid", o_in_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_err", o_err, 0);
      chk("rst_res_valid", o_res_valid, 0);
      chk("rst_idx", {o_co_idx, o_win_y, o_win_x}, 0);
      chk("rst_res_tag", {o_res_co, o_res_y, o_res_x}, 0);
      exp_issue_q.delete();
      inflight_q.delete();
      for (int c = 0; c < CO; c++)
         for (int y = 0; y < OY; y++)
            for (int x = 0; x < OX; x++)
               exp_issue_q.push_back(tag_of(c, y, x));
      issue_cnt = 0;
      res_cnt   = 0;
      credit_m  = CREDITS;
      stall_m   = 0;
      first_issue_cyc = -1;
      last_issue_cyc  = -1;
      last_res_cyc    = -1;
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic start_pass();
      @(posedge clk);
      #1 i_start = 1'b1;
      start_cyc = cyc;
      stall_m   = 0;
      @(posedge clk);
      #1 i_start = 1'b0;
   endtask

   task automatic run_to_done(input int budget, input bit rand_fmap);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(posedge clk);
         #1;
         if (rand_fmap) i_fmap_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (o_done) begin
            seen = 1'b1;
            done_cyc = cyc;
         end
      end
      chk("done_seen", seen, 1);
      i_fmap_ready = 1'b1;
   endtask

   initial begin
      // Back-to-back pass with immediate credit return; order checked by monitor
      do_reset();
      auto_ret = 1'b1;
      start_pass();
      @(negedge clk);
      chk("first_beat_after_start", o_in_valid, 1);
      run_to_done(100, 1'b0);
      chk("first_issue_cycle", first_issue_cyc, start_cyc + 1);
      chk("back_to_back_span", last_issue_cyc - first_issue_cyc, TOTAL - 1);
      chk("done_after_last_res", done_cyc - last_res_cyc, 1);
      chk("pass_issue_cnt", issue_cnt, TOTAL);
      chk("pass_res_cnt", res_cnt, TOTAL);
      chk("pass_all_issued", exp_issue_q.size(), 0);
      chk("pass_all_returned", inflight_q.size(), 0);
      chk("pass_err", o_err, 0);
      @(negedge clk);
      chk("done_one_cycle", o_done, 0);
      chk("idle_not_busy", o_busy, 0);

      // Credit starvation, single return, fire+return in the same cycle
      do_reset();
      auto_ret = 1'b0;
      start_pass();
      repeat (20) @(negedge clk);
      chk("starve_issue_cnt", issue_cnt, CREDITS);
      chk("starve_no_valid", o_in_valid, 0);
      @(posedge clk);
      #1;
`ifdef ST2_SCHED_PERF_EN
      chk("stall_cnt", o_stall_cnt, stall_m);
`endif
      manual_ret = 1'b1;
      @(posedge clk);
      #1 manual_ret = 1'b0;
      @(negedge clk);
      chk("ret_one_beat", o_in_valid, 1);
      @(negedge clk);
      chk("ret_then_stop", o_in_valid, 0);
      chk("ret_issue_cnt", issue_cnt, CREDITS + 1);
      @(posedge clk);
      #1 manual_ret = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("fire_with_ret", o_in_valid, 1);
      @(posedge clk);
      #1 manual_ret = 1'b0;
      @(negedge clk);
      chk("credit_held", o_in_valid, 1);
      @(negedge clk);
      chk("credit_spent", o_in_valid, 0);
      chk("fire_ret_issue_cnt", issue_cnt, CREDITS + 3);
      chk("starve_err", o_err, 0);

      // Random fmap readiness
      do_reset();
      auto_ret = 1'b1;
      start_pass();
      run_to_done(600, 1'b1);
      chk("rand_issue_cnt", issue_cnt, TOTAL);
      chk("rand_res_cnt", res_cnt, TOTAL);
      chk("rand_err", o_err, 0);

      // Ignored restart, then reset mid-pass and a clean rerun from (0,0,0)
      do_reset();
      auto_ret = 1'b1;
      start_pass();
      repeat (3) @(posedge clk);
      #1 i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
      @(negedge clk);
      chk("mid_busy", o_busy, 1);
      @(posedge clk);
      #1;
      do_reset();
      start_pass();
      run_to_done(100, 1'b0);
      chk("rerun_issue_cnt", issue_cnt, TOTAL);
      chk("rerun_res_cnt", res_cnt, TOTAL);
      chk("rerun_err", o_err, 0);

      // Spurious engine result while idle
      do_reset();
      auto_ret = 1'b0;
      @(negedge clk);
      chk("pre_spur_err", o_err, 0);
      @(posedge clk);
      #1 begin
         spur = 1'b1;
         skip_res = 1'b1;
      end
      @(negedge clk);
      chk("spur_res_valid", o_res_valid, 1);
      @(posedge clk);
      #1 spur = 1'b0;
      @(negedge clk);
      chk("spur_err_set", o_err, 1);
      repeat (5) @(negedge clk);
      chk("spur_err_sticky", o_err, 1);
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
